// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline hazard controller for the 5-stage core. It tracks which
// architectural registers are still waiting for a result from the single
// long-latency (mul/div) unit. It also decides, in the same cycle, whether
// fetch/decode must hold or whether fetch/decode/execute must be flushed.
// A saturating counter records how many cycles decode was stalled.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   valid_d                       decode holds a real instruction
//   rs1_d, rs2_d                  decode source registers
//   use_rs1_d, use_rs2_d          decode actually reads rs1 / rs2
//   rd_d, reg_write_d             decode destination and its write enable
//   long_d                        decode instruction targets the long unit
//   rd_e, load_e                  execute destination, execute holds a load
//   pc_src_e                      taken branch/jump resolved in execute
//   lu_done, lu_rd                long unit retires a result into lu_rd
//   stall_f, stall_d              hold PC / hold F/D register
//   flush_d, flush_e              clear F/D / clear D/E register
//   lu_issue                      decode instruction enters the long unit
//   busy_vec                      per-register pending bits
//   stall_cnt                     saturating count of stall_d cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  use_rs1_d,
  input  logic                  use_rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic                  long_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  load_e,
  input  logic                  pc_src_e,
  input  logic                  lu_done,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  lu_issue,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                lu_busy_q;
  logic                src1_used;
  logic                src2_used;
  logic                lu_haz;
  logic                raw_haz;
  logic                waw_haz;
  logic                str_haz;
  logic                hold;

  // Retire/issue masks. A register retiring this cycle is removed from the
  // effective busy view so the dependent instruction is released in the same
  // cycle instead of one cycle later. Register 0 never enters either mask.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (lu_done && (lu_rd != '0))
      clr_mask[lu_rd] = 1'b1;
    if (lu_issue && reg_write_d && (rd_d != '0))
      set_mask[rd_d] = 1'b1;
    eff_busy  = busy_q & ~clr_mask;
    // Set is applied after clear so a same-register retire+issue stays busy.
    busy_next = eff_busy | set_mask;
    busy_next[0] = 1'b0;
  end

  // Hazard terms, all qualified by a valid decode instruction.
  always_comb begin
    src1_used = use_rs1_d && (rs1_d != '0);
    src2_used = use_rs2_d && (rs2_d != '0);
    lu_haz  = valid_d && load_e && (rd_e != '0) &&
              ((src1_used && (rs1_d == rd_e)) || (src2_used && (rs2_d == rd_e)));
    raw_haz = valid_d && ((src1_used && eff_busy[rs1_d]) ||
                          (src2_used && eff_busy[rs2_d]));
    waw_haz = valid_d && reg_write_d && (rd_d != '0) && eff_busy[rd_d];
    // The long unit frees up this cycle if it is retiring, so only a busy
    // unit that is not finishing blocks a new long op.
    str_haz = valid_d && long_d && lu_busy_q && !lu_done;
    hold    = lu_haz || raw_haz || waw_haz || str_haz;
  end

  // Control outputs: redirect beats hold; everything is forced low while
  // reset is asserted so the pipeline sees no spurious stall/flush.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    lu_issue = 1'b0;
    if (rst_n) begin
      if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (hold) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        lu_issue = valid_d && long_d;
      end
    end
  end

  // Scoreboard and long-unit occupancy. An issue in the same cycle as a
  // retire keeps the unit occupied by the new op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      lu_busy_q <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (lu_issue)
        lu_busy_q <= 1'b1;
      else if (lu_done)
        lu_busy_q <= 1'b0;
    end
  end

  // Performance counter: counts decode stall cycles and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_d && (stall_cnt != {CNT_WIDTH{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign busy_vec = busy_q;

endmodule
